register_driver: RTL
====================

# register_driver

Command sequencer that drives the control and data pins of the 4-bit `register` block. It accepts one command at a time over a valid/ready handshake and expands it into a cycle-accurate sequence of strobes. The sequences are clear, parallel load, N-step increment or decrement, and 4-cycle serial loading through the shift-right or shift-left serial inputs. It sits between a host/test controller and a `register` instance, with outputs wired 1:1 to the `register` ports of the same name.

## Interface
Parameters: none.
- `clk` input 1: rising-edge clock, shared with the driven `register`.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: driver can accept a command; equals (state == IDLE).
- `cmd_op` input 3: opcode.
  - 000 NOP
  - 001 CLEAR
  - 010 LOAD
  - 011 INC_N
  - 100 DEC_N
  - 101 SER_R
  - 110 SER_L
  - 111 reserved
- `cmd_data` input 4: LOAD value, or serial payload.
- `cmd_cnt` input 3: step count for INC_N/DEC_N (0..7).
- `abort` input 1: synchronous abort of the running command.
- `cl`, `ld`, `inc`, `dec`, `sr`, `sl` output 1 each: `register` control strobes.
- `ir`, `il` output 1 each: serial bits for `sr`/`sl`.
- `in` output 4: parallel load data.
- `done` output 1: one-cycle pulse when a command completes normally.
- `aborted` output 1: one-cycle pulse when a command is aborted.
- `err` output 1: one-cycle pulse when opcode 111 is accepted.

## Operation
- States: IDLE, RUN.
  - Captured on accept (`cmd_valid & cmd_ready`): opcode, payload, and remaining-step counter `rem`.
- Strobe count per opcode:
  - CLEAR=1, LOAD=1, INC_N/DEC_N=`cmd_cnt`, SER_R/SER_L=4.
  - NOP, reserved, and INC_N/DEC_N with cnt=0 are zero-strobe commands.
- Zero-strobe command:
  - FSM stays in IDLE and `cmd_ready` stays 1.
  - `done` pulses the next cycle.
  - Reserved opcode additionally pulses `err` in that same cycle.
- Non-zero command: IDLE→RUN. Each RUN cycle drives exactly one strobe and decrements `rem`. On `rem` reaching 0, RUN→IDLE.
- Strobe content:
  - CLEAR: `cl`=1.
  - LOAD: `ld`=1, `in`=`cmd_data`.
  - INC_N: `inc`=1 each step.
  - DEC_N: `dec`=1 each step.
  - SER_R: `sr`=1. Step k (k=0..3) drives `ir`=`cmd_data[k]` (LSB first), so the register holds `cmd_data` after 4 steps.
  - SER_L: `sl`=1. Step k drives `il`=`cmd_data[3-k]` (MSB first), so the register holds `cmd_data` after 4 steps.
- Output hygiene:
  - Never more than one of `cl`/`ld`/`inc`/`dec`/`sr`/`sl` is high in the same cycle.
  - `in`, `ir`, `il` are 0 whenever their qualifying strobe is 0.
- Abort:
  - `abort` sampled high in RUN: next cycle all strobes are 0, FSM is in IDLE, `aborted`=1, `done`=0.
  - Steps already issued are not undone.
  - `abort` in IDLE is ignored; it does not cancel a command accepted in the same cycle.
- Counter width: `rem` is 3 bits; max 7 steps. No wrap — the count loads only on accept.

## Timing
- All outputs except `cmd_ready` are registered.
- Reset values:
  - All strobes, `in`=0000, `ir`=`il`=0, `done`=`aborted`=`err`=0.
  - State IDLE, so `cmd_ready`=1.
- Reset asserted mid-command: outputs clear immediately (asynchronously) and the command is lost with no `done`.
- Latency: first strobe appears the cycle after the accept edge.
- Occupancy:
  - An N-strobe command holds `cmd_ready` low for N cycles.
  - `done` is high in the first IDLE cycle after the last strobe, concurrent with `cmd_ready`=1.
- Back-to-back: a new command may be accepted in the `done` cycle; its first strobe immediately follows, with no gap cycle.
- Handshake: `cmd_*` fields are sampled only at the accept edge and may change afterward.

## Test plan
- After reset: `cmd_ready`=1 and all outputs 0. LOAD `cmd_data`=1010 → `ld`=1, `in`=1010 for 1 cycle; `done` next cycle; paired `register` out=1010.
- LOAD 0011, then INC_N cnt=5 → `inc` high 5 consecutive cycles, register=1000. DEC_N cnt=0 → no strobe, `done` next cycle, register unchanged.
- CLEAR, then SER_R 1101 → `sr` high 4 cycles with `ir`=1,0,1,1; register=1101. SER_L 0110 → `il`=0,1,1,0; register=0110.
- INC_N cnt=7 from 1110 → register wraps to 0101. Issue back-to-back CLEAR in the `done` cycle → `cl` strobe in the very next cycle.
- SER_R 1111 with `abort` on step 2 → exactly 2 `sr` pulses, `aborted`=1, `done` never high, register=11xx (upper bits 1, lower bits from prior contents).
- Opcode 111 → `err` and `done` pulse together, no strobes. Assert `rst_n`=0 during INC_N cnt=6 → outputs 0 immediately, `cmd_ready`=1 after release.

Source files
------------

// File: rtl/register_driver.sv
// Command sequencer for the 4-bit register block: expands one accepted command
// into a cycle-accurate train of register strobes (clear, load, inc/dec, serial).

module register_driver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    input  logic [2:0] cmd_cnt,
    input  logic       abort,
    output logic       cl,
    output logic       ld,
    output logic       inc,
    output logic       dec,
    output logic       sr,
    output logic       sl,
    output logic       ir,
    output logic       il,
    output logic [3:0] in,
    output logic       done,
    output logic       aborted,
    output logic       err
);

    // state | meaning
    // IDLE  | ready for a command; zero-strobe commands complete here
    // RUN   | one strobe per cycle until rem is exhausted or abort
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_CLEAR = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_DEC   = 3'b100;
    localparam logic [2:0] OP_SER_R = 3'b101;
    localparam logic [2:0] OP_SER_L = 3'b110;
    localparam logic [2:0] OP_RSV   = 3'b111;

    state_t      state, state_nxt;
    logic [2:0]  op_q, op_nxt;
    logic [3:0]  shreg, shreg_nxt;
    logic [2:0]  rem, rem_nxt;
    logic [11:0] strb_q, strb_nxt;
    logic        done_nxt, aborted_nxt, err_nxt;
    logic [2:0]  steps;

    function automatic logic [2:0] step_count(input logic [2:0] op, input logic [2:0] cnt);
        case (op)
            OP_CLEAR, OP_LOAD: step_count = 3'd1;
            OP_INC, OP_DEC:    step_count = cnt;
            OP_SER_R, OP_SER_L: step_count = 3'd4;
            default:           step_count = 3'd0;
        endcase
    endfunction

    // Packed as {cl, ld, inc, dec, sr, sl, in[3:0], ir, il}; serial bits come
    // from the edge of the shift register that leads for that direction.
    function automatic logic [11:0] strobe_of(input logic [2:0] op, input logic [3:0] data);
        strobe_of = '0;
        case (op)
            OP_CLEAR: strobe_of[11]  = 1'b1;
            OP_LOAD:  strobe_of      = {6'b010000, data, 2'b00};
            OP_INC:   strobe_of[9]   = 1'b1;
            OP_DEC:   strobe_of[8]   = 1'b1;
            OP_SER_R: strobe_of      = {6'b000010, 4'b0000, data[0], 1'b0};
            OP_SER_L: strobe_of      = {6'b000001, 4'b0000, 1'b0, data[3]};
            default:  strobe_of      = '0;
        endcase
    endfunction

    function automatic logic [3:0] shift_next(input logic [2:0] op, input logic [3:0] data);
        shift_next = (op == OP_SER_L) ? {data[2:0], 1'b0} : {1'b0, data[3:1]};
    endfunction

    assign steps     = step_count(cmd_op, cmd_cnt);
    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_nxt   = state;
        op_nxt      = op_q;
        shreg_nxt   = shreg;
        rem_nxt     = rem;
        strb_nxt    = '0;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (steps == 3'd0) begin
                        done_nxt = 1'b1;
                        err_nxt  = (cmd_op == OP_RSV);
                    end else begin
                        state_nxt = RUN;
                        op_nxt    = cmd_op;
                        strb_nxt  = strobe_of(cmd_op, cmd_data);
                        shreg_nxt = shift_next(cmd_op, cmd_data);
                        rem_nxt   = steps - 3'd1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    aborted_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else if (rem == 3'd0) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    strb_nxt  = strobe_of(op_q, shreg);
                    shreg_nxt = shift_next(op_q, shreg);
                    rem_nxt   = rem - 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_NOP;
            shreg   <= '0;
            rem     <= '0;
            strb_q  <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_q    <= op_nxt;
            shreg   <= shreg_nxt;
            rem     <= rem_nxt;
            strb_q  <= strb_nxt;
            done    <= done_nxt;
            aborted <= aborted_nxt;
            err     <= err_nxt;
        end
    end

    assign {cl, ld, inc, dec, sr, sl, in, ir, il} = strb_q;

endmodule
